// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, S-box and key helpers
package aes_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef logic [127:0] key_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREEXP = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Rcon[1] is the most significant byte
  localparam logic [79:0] RCON_FLAT = 80'h01020408102040801b36;

  // S-box entry 0 is the most significant byte, shared with the cipher SubBytes
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd10) return RCON_FLAT[(10 - int'(idx)) * 8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// rtl/aes_key_scheduler_if.sv - key-load and round-key stream bundle
interface aes_key_scheduler_if;
  import aes_pkg::*;

  logic       i_Start;
  key_t       i_Key;
  logic       i_fDec;
  logic       o_Busy;
  key_t       o_RoundKey;
  logic [3:0] o_RoundNum;
  logic       o_KeyValid;
  logic       i_KeyReady;
  logic       o_Done;

  modport master (
    output i_Start, i_Key, i_fDec, i_KeyReady,
    input  o_Busy, o_RoundKey, o_RoundNum, o_KeyValid, o_Done
  );

  modport slave (
    input  i_Start, i_Key, i_fDec, i_KeyReady,
    output o_Busy, o_RoundKey, o_RoundNum, o_KeyValid, o_Done
  );

endinterface

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one combinational forward or inverse AES-128 key-expansion step
module aes_key_step
  import aes_pkg::*;
(
  input  key_t       key,
  input  logic [3:0] round_num,
  input  logic       dec,
  output key_t       next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  rc_idx;
  logic [31:0] rc_word;

  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    // forward builds round_num+1 from round_num; inverse undoes round_num itself
    rc_idx  = dec ? round_num : round_num + 4'd1;
    rc_word = {rcon(rc_idx), 24'h000000};
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    if (dec) begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ sub_rot_word(n3) ^ rc_word;
    end else begin
      n0 = w0 ^ sub_rot_word(w3) ^ rc_word;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// rtl/aes_key_scheduler.sv - sequential AES-128 round-key scheduler streaming keys 0..10 or 10..0
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input logic                 i_Clk,
  input logic                 i_Rstn,
  aes_key_scheduler_if.slave  bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [1:0] state_q, state_d;
  key_t       key_q, key_d;
  logic [3:0] round_q, round_d;
  logic       fdec_q, fdec_d;

  key_t       step_key;
  logic       step_dec;

  // pre-expansion always runs forward, only EMIT in decrypt order walks back
  assign step_dec = (state_q == ST_EMIT) && fdec_q;

  aes_key_step u_step (
    .key       (key_q),
    .round_num (round_q),
    .dec       (step_dec),
    .next_key  (step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    fdec_d  = fdec_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Start) begin
          key_d   = bus.i_Key;
          fdec_d  = bus.i_fDec;
          round_d = 4'd0;
          state_d = bus.i_fDec ? ST_PREEXP : ST_EMIT;
        end
      end
      ST_PREEXP: begin
        key_d   = step_key;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND - 4'd1) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.i_KeyReady) begin
          if (fdec_q ? (round_q == 4'd0) : (round_q == LAST_ROUND)) begin
            state_d = ST_DONE;
          end else begin
            key_d   = step_key;
            round_d = fdec_q ? round_q - 4'd1 : round_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
      fdec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      fdec_q  <= fdec_d;
    end
  end

  assign bus.o_Busy     = (state_q != ST_IDLE);
  assign bus.o_KeyValid = (state_q == ST_EMIT);
  assign bus.o_Done     = (state_q == ST_DONE);
  assign bus.o_RoundKey = key_q;
  assign bus.o_RoundNum = round_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// tb/tb_aes_key_scheduler.sv - randomized self-checking bench against a FIPS-197 expansion model
module tb_aes_key_scheduler;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  aes_key_scheduler_if bus();

  aes_key_scheduler #(.NUM_ROUNDS(10)) dut (
    .i_Clk  (clk),
    .i_Rstn (rstn),
    .bus    (bus)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   sb[256];
  logic [127:0] ref_keys[11];
  logic [127:0] got_keys[11];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15 - n -: 8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] a = 8'(v);
      if (v == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run(input logic [127:0] key, input logic dec, input int ready_pct,
                     input bit poke_start, input int abort_idx);
    int cnt, hs, exp_idx;
    bit stalled, rdy, was_valid;
    logic [127:0] held;
    expand(key);
    for (int r = 0; r < 11; r++) got_keys[r] = '0;
    cnt = 0;
    while (bus.o_Busy && cnt < 50) begin @(negedge clk); cnt++; end
    chk("idle_before_start", bus.o_Busy, 0);
    bus.i_Key = key; bus.i_fDec = dec; bus.i_Start = 1'b1; bus.i_KeyReady = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.i_Start = 1'b0; bus.i_Key = {$urandom, $urandom, $urandom, $urandom}; bus.i_fDec = ~dec;
    chk("busy_after_start", bus.o_Busy, 1);
    cnt = 0;
    while (!bus.o_KeyValid && cnt < 30) begin @(negedge clk); cnt++; end
    chk("first_key_latency", cnt, dec ? 10 : 0);
    exp_idx = dec ? 10 : 0; hs = 0; stalled = 0; held = '0;
    for (int it = 0; it < 500 && hs < 11; it++) begin
      chk("valid_in_emit", bus.o_KeyValid, 1);
      chk("round_num", bus.o_RoundNum, exp_idx);
      chk("round_key", bus.o_RoundKey, ref_keys[exp_idx]);
      if (stalled) chk("key_held_in_stall", bus.o_RoundKey, held);
      chk("no_early_done", bus.o_Done, 0);
      got_keys[exp_idx] = bus.o_RoundKey;
      if (abort_idx == exp_idx) begin
        rstn = 1'b0; bus.i_KeyReady = 1'(($urandom));
        @(posedge clk); @(negedge clk);
        chk("rst_busy", bus.o_Busy, 0);
        chk("rst_valid", bus.o_KeyValid, 0);
        chk("rst_done", bus.o_Done, 0);
        chk("rst_key", bus.o_RoundKey, 0);
        chk("rst_round", bus.o_RoundNum, 0);
        rstn = 1'b1; bus.i_KeyReady = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("no_done_after_abort", bus.o_Done, 0);
          chk("idle_after_abort", bus.o_Busy, 0);
        end
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      bus.i_KeyReady = rdy;
      bus.i_Start = poke_start && (hs == 3);
      bus.i_Key = ~key; bus.i_fDec = ~dec;
      was_valid = bus.o_KeyValid; held = bus.o_RoundKey;
      @(posedge clk); @(negedge clk);
      bus.i_Start = 1'b0;
      stalled = was_valid && !rdy;
      if (was_valid && rdy) begin
        hs++;
        if (hs < 11) exp_idx = dec ? exp_idx - 1 : exp_idx + 1;
      end
    end
    bus.i_KeyReady = 1'b0;
    chk("handshakes", hs, 11);
    chk("done_pulse", bus.o_Done, 1);
    chk("valid_off_at_done", bus.o_KeyValid, 0);
    chk("busy_during_done", bus.o_Busy, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.o_Done, 0);
    chk("busy_off_after_done", bus.o_Busy, 0);
  endtask

  initial begin
    build_sbox();
    bus.i_Start = 1'b0; bus.i_Key = '0; bus.i_fDec = 1'b0; bus.i_KeyReady = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.o_Busy, 0);
    chk("reset_valid", bus.o_KeyValid, 0);
    chk("reset_done", bus.o_Done, 0);
    chk("reset_key", bus.o_RoundKey, 0);
    chk("reset_round", bus.o_RoundNum, 0);
    rstn = 1'b1;
    @(negedge clk);

    run(FIPS_KEY, 1'b0, 100, 1'b0, -1);
    chk("fips_enc_k0", got_keys[0], FIPS_KEY);
    chk("fips_enc_k1", got_keys[1], FIPS_K1);
    chk("fips_enc_k10", got_keys[10], FIPS_K10);

    run(FIPS_KEY, 1'b1, 100, 1'b0, -1);
    chk("fips_dec_k10", got_keys[10], FIPS_K10);
    chk("fips_dec_k1", got_keys[1], FIPS_K1);
    chk("fips_dec_k0", got_keys[0], FIPS_KEY);

    run(FIPS_KEY, 1'b0, 30, 1'b0, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 30, 1'b0, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 100, 1'b1, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 30, 1'b1, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 30, 1'b0, 5);
    run(FIPS_KEY, 1'b0, 100, 1'b0, -1);
    chk("post_abort_k10", got_keys[10], FIPS_K10);
    run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 50, 1'b0, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 100, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
